// File: rtl/trace_packet_fifo.sv
// Trace packet buffer: aligns the retired-instruction stream with the filter's late drop
// decision and queues kept packets; optional timestamp field under TRACE_PKT_TIMESTAMP_EN.
module trace_packet_fifo #(
   parameter int PC_WIDTH    = 64,
   parameter int INSTR_WIDTH = 32,
   parameter int FIFO_DEPTH  = 16,
   parameter int CNT_WIDTH   = 16,
   parameter int TS_WIDTH    = 32,
`ifdef TRACE_PKT_TIMESTAMP_EN
   localparam int TS_EN      = 1,
`else
   localparam int TS_EN      = 0,
`endif
   localparam int PKT_W      = TS_EN * TS_WIDTH + 1 + PC_WIDTH + INSTR_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   instr_valid,
   input  logic [PC_WIDTH-1:0]    pc,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic                   drop_instr,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [PKT_W-1:0]       m_tdata,
   output logic                   overflow,
   output logic [CNT_WIDTH-1:0]   overflow_cnt,
   input  logic                   clear
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic                   s1_valid_r, s2_valid_r;
   logic [PC_WIDTH-1:0]    s1_pc_r, s2_pc_r;
   logic [INSTR_WIDTH-1:0] s1_instr_r, s2_instr_r;
   logic [AW:0]            wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s;
   logic                   gap_pending_r;
   logic                   overflow_r;
   logic [CNT_WIDTH-1:0]   overflow_cnt_r;
   logic                   m_tvalid_r;
   logic [PKT_W-1:0]       mem_r [FIFO_DEPTH];
   logic [PKT_W-1:0]       wdata_s;
   logic                   push_req_s, empty_s, full_s, pop_s, push_ok_s, ovf_s;

`ifdef TRACE_PKT_TIMESTAMP_EN
   logic [TS_WIDTH-1:0]    ts_cnt_r, s1_ts_r, s2_ts_r;

   // Free-running timestamp, sampled into the pipe alongside each instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt_r <= {TS_WIDTH{1'b0}};
         s1_ts_r  <= {TS_WIDTH{1'b0}};
         s2_ts_r  <= {TS_WIDTH{1'b0}};
      end else begin
         ts_cnt_r <= ts_cnt_r + TS_WIDTH'(1);
         s1_ts_r  <= ts_cnt_r;
         s2_ts_r  <= s1_ts_r;
      end
   end

   assign wdata_s = {s2_ts_r, gap_pending_r, s2_pc_r, s2_instr_r};
`else
   assign wdata_s = {gap_pending_r, s2_pc_r, s2_instr_r};
`endif

   // Two-stage delay so stage 2 lines up with the filter's drop decision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s2_valid_r <= 1'b0;
         s1_pc_r    <= {PC_WIDTH{1'b0}};
         s2_pc_r    <= {PC_WIDTH{1'b0}};
         s1_instr_r <= {INSTR_WIDTH{1'b0}};
         s2_instr_r <= {INSTR_WIDTH{1'b0}};
      end else begin
         s1_valid_r <= instr_valid;
         s2_valid_r <= s1_valid_r;
         s1_pc_r    <= pc;
         s2_pc_r    <= s1_pc_r;
         s1_instr_r <= instr;
         s2_instr_r <= s1_instr_r;
      end
   end

   // Push/pop qualification; a pop in the same cycle frees the slot for a push into a full FIFO
   always_comb begin
      push_req_s = s2_valid_r & ~drop_instr;
      empty_s    = (wr_ptr_r == rd_ptr_r);
      full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      pop_s      = ~empty_s & m_tready;
      push_ok_s  = push_req_s & (~full_s | pop_s);
      ovf_s      = push_req_s & full_s & ~pop_s;
      if (push_ok_s) begin
         wr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_nxt_s = rd_ptr_r;
      end
   end

   // Pointers, in-band gap marker and registered valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r      <= {(AW+1){1'b0}};
         rd_ptr_r      <= {(AW+1){1'b0}};
         gap_pending_r <= 1'b0;
         m_tvalid_r    <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_nxt_s;
         rd_ptr_r   <= rd_nxt_s;
         m_tvalid_r <= (wr_nxt_s != rd_nxt_s);
         if (push_ok_s) begin
            gap_pending_r <= 1'b0;
         end else if (ovf_s) begin
            gap_pending_r <= 1'b1;
         end else begin
            gap_pending_r <= gap_pending_r;
         end
      end
   end

   // Overflow flag and saturating lost-packet counter; clear beats a same-cycle overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r     <= 1'b0;
         overflow_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (clear) begin
         overflow_r     <= 1'b0;
         overflow_cnt_r <= ovf_s ? CNT_ONE : {CNT_WIDTH{1'b0}};
      end else if (ovf_s) begin
         overflow_r     <= 1'b1;
         overflow_cnt_r <= (overflow_cnt_r == CNT_MAX) ? CNT_MAX : overflow_cnt_r + CNT_ONE;
      end else begin
         overflow_r     <= overflow_r;
         overflow_cnt_r <= overflow_cnt_r;
      end
   end

   // Packet storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wdata_s;
      end
   end

   assign m_tvalid     = m_tvalid_r;
   assign m_tdata      = mem_r[rd_ptr_r[AW-1:0]];
   assign overflow     = overflow_r;
   assign overflow_cnt = overflow_cnt_r;

endmodule

// File: tb/tb_trace_packet_fifo.sv
// Directed bench for trace_packet_fifo in its default build (no timestamp field).
module tb_trace_packet_fifo;

   localparam int PKT_W = 97;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              instr_valid;
   logic [63:0]       pc;
   logic [31:0]       instr;
   logic              drop_instr;
   logic              m_tvalid;
   logic              m_tready;
   logic [PKT_W-1:0]  m_tdata;
   logic              overflow;
   logic [15:0]       overflow_cnt;
   logic              clear;

   int errors = 0;
   int checks = 0;
   logic [95:0]      expq [$];
   logic [PKT_W-1:0] rxq  [$];
   bit h0, h1;
   bit prev_stall;
   logic [PKT_W-1:0] prev_data;

   trace_packet_fifo dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc(pc), .instr(instr),
      .drop_instr(drop_instr), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .overflow(overflow), .overflow_cnt(overflow_cnt), .clear(clear)
   );

   always #5 clk = ~clk;

   // Collect accepted packets and confirm stalled data holds
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== prev_data) begin
               errors++;
               $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                        m_tvalid, m_tdata, prev_data);
            end
         end
         if (m_tvalid && m_tready) rxq.push_back(m_tdata);
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
      end
   end

   // One cycle: drive inputs; drop_instr is the decision for the instruction two steps back
   task automatic step(input bit v, input logic [63:0] p, input logic [31:0] i,
                       input bit d, input bit rdy, input bit clr);
      @(posedge clk); #1;
      instr_valid = v; pc = p; instr = i;
      drop_instr = h1; h1 = h0; h0 = d;
      m_tready = rdy; clear = clr;
      if (v && !d) expq.push_back({p, i});
   endtask

   task automatic idle(input int n, input bit rdy);
      repeat (n) step(1'b0, 64'h0, 32'h0, 1'b0, rdy, 1'b0);
   endtask

   task automatic clr_q();
      expq.delete();
      rxq.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; instr_valid = 1'b0; pc = 64'h0; instr = 32'h0;
      drop_instr = 1'b0; m_tready = 1'b0; clear = 1'b0; h0 = 1'b0; h1 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      clr_q();
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_tvalid); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
      checks++; if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", overflow_cnt); end
   endtask

   task automatic test_single();
      logic exp_v;
      clr_q();
      step(1'b1, 64'h8000_0000, 32'h0000_0063, 1'b0, 1'b1, 1'b0);
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_c0: got %b expected 0", m_tvalid); end
      for (int k = 1; k <= 4; k++) begin
         idle(1, 1'b1);
         exp_v = (k == 3);
         checks++;
         if (m_tvalid !== exp_v) begin
            errors++; $display("FAIL single_valid_c%0d: got %b expected %b", k, m_tvalid, exp_v);
         end
         if (k == 3) begin
            checks++;
            if (m_tdata !== {1'b0, 64'h8000_0000, 32'h0000_0063}) begin
               errors++; $display("FAIL single_data: got %h expected %h", m_tdata, {1'b0, 64'h8000_0000, 32'h0000_0063});
            end
         end
      end
   endtask

   task automatic test_drop();
      logic [PKT_W-1:0] got;
      clr_q();
      step(1'b1, 64'hA000, 32'h1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 64'hB000, 32'h2, 1'b0, 1'b1, 1'b0);
      step(1'b1, 64'hC000, 32'h3, 1'b1, 1'b1, 1'b0);
      idle(6, 1'b1);
      checks++; if (rxq.size() != 1) begin errors++; $display("FAIL drop_count: got %0d expected 1", rxq.size()); end
      got = (rxq.size() > 0) ? rxq[0] : {PKT_W{1'bx}};
      checks++; if (got !== {1'b0, 64'hB000, 32'h2}) begin errors++; $display("FAIL drop_data: got %h expected %h", got, {1'b0, 64'hB000, 32'h2}); end
   endtask

   task automatic test_fill();
      logic [PKT_W-1:0] got, exp;
      clr_q();
      for (int i = 0; i < 16; i++) step(1'b1, 64'h1000 + 64'(i), 32'h13 + 32'(i), 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 2; j++) step(1'b1, 64'h2000 + 64'(j), 32'h99, 1'b0, 1'b0, 1'b0);
      idle(3, 1'b0);
      checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b expected 1", m_tvalid); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf: got %b expected 1", overflow); end
      checks++; if (overflow_cnt !== 16'd2) begin errors++; $display("FAIL fill_cnt: got %0d expected 2", overflow_cnt); end
      step(1'b1, 64'h3000, 32'h77, 1'b0, 1'b1, 1'b0);
      idle(24, 1'b1);
      checks++; if (rxq.size() != 17) begin errors++; $display("FAIL fill_count: got %0d expected 17", rxq.size()); end
      for (int i = 0; i < 17; i++) begin
         exp = (i < 16) ? {1'b0, 64'h1000 + 64'(i), 32'h13 + 32'(i)} : {1'b1, 64'h3000, 32'h77};
         got = (i < rxq.size()) ? rxq[i] : {PKT_W{1'bx}};
         checks++;
         if (got !== exp) begin errors++; $display("FAIL fill_pkt%0d: got %h expected %h", i, got, exp); end
      end
   endtask

   task automatic test_full_pop_push();
      logic [PKT_W-1:0] got, exp;
      clr_q();
      step(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, 64'h4000 + 64'(i), 32'h40 + 32'(i), 1'b0, 1'b0, 1'b0);
      idle(3, 1'b0);
      checks++; if (overflow !== 1'b0 || overflow_cnt !== 16'd0) begin errors++; $display("FAIL fpp_cleared: got ovf=%b cnt=%0d expected ovf=0 cnt=0", overflow, overflow_cnt); end
      step(1'b1, 64'h5000, 32'h99, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      idle(1, 1'b1);
      idle(1, 1'b0);
      checks++; if (overflow !== 1'b0 || overflow_cnt !== 16'd0) begin errors++; $display("FAIL fpp_no_ovf: got ovf=%b cnt=%0d expected ovf=0 cnt=0", overflow, overflow_cnt); end
      idle(22, 1'b1);
      checks++; if (rxq.size() != 17) begin errors++; $display("FAIL fpp_count: got %0d expected 17", rxq.size()); end
      for (int i = 0; i < 17; i++) begin
         exp = (i < 16) ? {1'b0, 64'h4000 + 64'(i), 32'h40 + 32'(i)} : {1'b0, 64'h5000, 32'h99};
         got = (i < rxq.size()) ? rxq[i] : {PKT_W{1'bx}};
         checks++;
         if (got !== exp) begin errors++; $display("FAIL fpp_pkt%0d: got %h expected %h", i, got, exp); end
      end
   endtask

   task automatic test_backpressure();
      int sent = 0;
      int cyc = 0;
      int mism = 0;
      bit v, d;
      clr_q();
      while (sent < 1000 && cyc < 20000) begin
         v = ((sent - rxq.size()) < 12) && ($urandom_range(1, 0) == 1);
         d = ($urandom_range(3, 0) == 0);
         step(v, {$urandom, $urandom}, $urandom, d, ($urandom_range(1, 0) == 1), 1'b0);
         if (v && !d) sent++;
         cyc++;
      end
      idle(40, 1'b1);
      checks++; if (rxq.size() != 1000) begin errors++; $display("FAIL bp_count: got %0d expected 1000", rxq.size()); end
      for (int i = 0; i < rxq.size() && i < expq.size(); i++) begin
         if (rxq[i] !== {1'b0, expq[i]}) mism++;
      end
      checks++; if (mism != 0) begin errors++; $display("FAIL bp_order: got %0d mismatched packets expected 0", mism); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf: got %b expected 0", overflow); end
   endtask

   task automatic test_reset_mid();
      logic [PKT_W-1:0] got;
      clr_q();
      for (int i = 0; i < 17; i++) step(1'b1, 64'h6100 + 64'(i), 32'h61, 1'b0, 1'b0, 1'b0);
      idle(3, 1'b0);
      checks++; if (overflow !== 1'b1 || overflow_cnt !== 16'd1) begin errors++; $display("FAIL rm_pre: got ovf=%b cnt=%0d expected ovf=1 cnt=1", overflow, overflow_cnt); end
      @(posedge clk); #2;
      rst_n = 1'b0; instr_valid = 1'b0;
      #1;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rm_valid_async: got %b expected 0", m_tvalid); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      h0 = 1'b0; h1 = 1'b0; drop_instr = 1'b0;
      clr_q();
      checks++; if (overflow !== 1'b0 || overflow_cnt !== 16'd0) begin errors++; $display("FAIL rm_counters: got ovf=%b cnt=%0d expected ovf=0 cnt=0", overflow, overflow_cnt); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rm_valid_after: got %b expected 0", m_tvalid); end
      step(1'b1, 64'h6000, 32'h55, 1'b0, 1'b1, 1'b0);
      idle(5, 1'b1);
      got = (rxq.size() > 0) ? rxq[0] : {PKT_W{1'bx}};
      checks++; if (rxq.size() != 1 || got !== {1'b0, 64'h6000, 32'h55}) begin errors++; $display("FAIL rm_next_pkt: got n=%0d %h expected n=1 %h", rxq.size(), got, {1'b0, 64'h6000, 32'h55}); end
   endtask

   task automatic test_clear_overflow();
      logic [PKT_W-1:0] got;
      clr_q();
      for (int i = 0; i < 16; i++) step(1'b1, 64'h7000 + 64'(i), 32'h70, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'h7100, 32'h71, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'h7101, 32'h71, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'h7102, 32'h71, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      step(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      checks++; if (overflow !== 1'b1 || overflow_cnt !== 16'd2) begin errors++; $display("FAIL co_pre: got ovf=%b cnt=%0d expected ovf=1 cnt=2", overflow, overflow_cnt); end
      idle(2, 1'b0);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL co_flag: got %b expected 0", overflow); end
      checks++; if (overflow_cnt !== 16'd1) begin errors++; $display("FAIL co_cnt: got %0d expected 1", overflow_cnt); end
      idle(20, 1'b1);
      step(1'b1, 64'h7200, 32'h22, 1'b0, 1'b1, 1'b0);
      idle(5, 1'b1);
      checks++; if (rxq.size() != 17) begin errors++; $display("FAIL co_count: got %0d expected 17", rxq.size()); end
      got = (rxq.size() > 16) ? rxq[16] : {PKT_W{1'bx}};
      checks++; if (got !== {1'b1, 64'h7200, 32'h22}) begin errors++; $display("FAIL co_gap_pkt: got %h expected %h", got, {1'b1, 64'h7200, 32'h22}); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_drop();
      test_fill();
      test_full_pop_push();
      test_backpressure();
      test_reset_mid();
      test_clear_overflow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
